// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: drives a 1-bit ALU slice LSB first, one bit per cycle,
// and assembles the WIDTH-bit result and flags behind a start/done handshake.
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       dbg_state_o
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Slice controls: {legal, Ainvert, Binvert, CarryIn, Operation[1:0]}
    function automatic logic [5:0] decode(input logic [2:0] opc);
        case (opc)
            3'b000:  decode = 6'b1_000_00;
            3'b001:  decode = 6'b1_000_01;
            3'b010:  decode = 6'b1_000_10;
            3'b110:  decode = 6'b1_011_10;
            3'b111:  decode = 6'b1_011_10;
            3'b100:  decode = 6'b1_110_00;
            default: decode = 6'b0_000_00;
        endcase
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [5:0]       ctl_run, ctl_new;
    logic             a_bit, b_bit, slice_bit, slice_cout, ovf_bit;
    logic             last_bit, is_slt, is_arith;
    logic [WIDTH-1:0] shifted, final_res;

    always_comb begin
        ctl_run    = decode(op_q);
        ctl_new    = decode(op);
        a_bit      = a_q[idx_q] ^ ctl_run[4];
        b_bit      = b_q[idx_q] ^ ctl_run[3];
        case (ctl_run[1:0])
            2'b00:   slice_bit = a_bit & b_bit;
            2'b01:   slice_bit = a_bit | b_bit;
            default: slice_bit = a_bit ^ b_bit ^ carry_q;
        endcase
        if (!ctl_run[5]) begin
            slice_bit = 1'b0;
        end
        slice_cout = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
        ovf_bit    = carry_q ^ slice_cout;
        last_bit   = (idx_q == IW'(WIDTH - 1));
        is_slt     = (op_q == 3'b111);
        is_arith   = (op_q == 3'b010) || (op_q == 3'b110);
        shifted    = {slice_bit, result_q[WIDTH-1:1]};
        // SLT keeps only the corrected sign of the serial difference.
        final_res  = is_slt ? {{(WIDTH-1){1'b0}}, slice_bit ^ ovf_bit} : shifted;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    carry_d = ctl_new[2];
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (last_bit) begin
                    result_d = final_res;
                    cout_d   = is_arith & slice_cout;
                    ovf_d    = is_arith & ovf_bit;
                    zero_d   = (final_res == '0);
                    state_d  = S_DONE;
                end else begin
                    result_d = shifted;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;
    assign carry_out   = cout_q;
    assign overflow    = ovf_q;
    assign zero        = zero_q;
    assign dbg_state_o = state_q;

endmodule
